// File: rtl/rx_cmd_parser_pkg.sv
// rx_cmd_parser shared types: opcodes, command/error encodings,
// parser FSM states and the opcode decoder.
package rx_cmd_parser_pkg;

  localparam logic [7:0] OPC_WR  = 8'hAA;
  localparam logic [7:0] OPC_RD  = 8'hBB;
  localparam logic [7:0] OPC_ALU = 8'hCC;
  localparam logic [7:0] OPC_NOP = 8'hDD;

  typedef enum logic [1:0] {
    CMD_WR      = 2'b00,
    CMD_RD      = 2'b01,
    CMD_ALU_OP  = 2'b10,
    CMD_ALU_NOP = 2'b11
  } cmd_type_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'b00,
    ERR_OPC     = 2'b01,
    ERR_TIMEOUT = 2'b10,
    ERR_OVERRUN = 2'b11
  } err_code_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GET_ADDR,
    ST_GET_D0,
    ST_GET_D1,
    ST_GET_FUN,
    ST_HOLD
  } state_e;

  typedef struct packed {
    logic      ok;
    cmd_type_e typ;
    state_e    nxt;
  } opc_dec_t;

  function automatic opc_dec_t opc_decode(input logic [7:0] b);
    opc_dec_t r;
    r.ok  = 1'b1;
    r.typ = CMD_WR;
    r.nxt = ST_GET_ADDR;
    case (b)
      OPC_WR:  r.typ = CMD_WR;
      OPC_RD:  r.typ = CMD_RD;
      OPC_ALU: begin
        r.typ = CMD_ALU_OP;
        r.nxt = ST_GET_D0;
      end
      OPC_NOP: begin
        r.typ = CMD_ALU_NOP;
        r.nxt = ST_GET_FUN;
      end
      default: begin
        r.ok  = 1'b0;
        r.nxt = ST_IDLE;
      end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/rx_cmd_parser_if.sv
// Byte-in / command-out bundle of the frame parser.
// master = parser side, slave = byte source and command consumer.
interface rx_cmd_parser_if #(
  parameter int D_WIDTH    = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int FUN_WIDTH  = 4
);
  import rx_cmd_parser_pkg::*;

  logic [D_WIDTH-1:0]    rx_data;
  logic                  rx_valid;
  logic                  cmd_ready;
  logic                  cmd_valid;
  cmd_type_e             cmd_type;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [D_WIDTH-1:0]    cmd_d0;
  logic [D_WIDTH-1:0]    cmd_d1;
  logic [FUN_WIDTH-1:0]  cmd_fun;
  logic                  err_pulse;
  err_code_e             err_code;

  modport master (
    input  rx_data, rx_valid, cmd_ready,
    output cmd_valid, cmd_type, cmd_addr,
    output cmd_d0, cmd_d1, cmd_fun,
    output err_pulse, err_code
  );

  modport slave (
    output rx_data, rx_valid, cmd_ready,
    input  cmd_valid, cmd_type, cmd_addr,
    input  cmd_d0, cmd_d1, cmd_fun,
    input  err_pulse, err_code
  );

endinterface

// File: rtl/rx_cmd_parser_frame_timeout_cnt.sv
// Inter-byte idle counter; expired flags the last
// allowed idle cycle of a partially received frame.
module frame_timeout_cnt #(
  parameter int TIMEOUT = 1024,
  localparam int CW = $clog2(TIMEOUT)
) (
  input  logic CLK,
  input  logic RST,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // clear has priority over increment
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // counter register
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/rx_cmd_parser.sv
// Assembles synchronized bytes into WR/RD/ALU commands,
// holds each until accepted, flags opcode/timeout/overrun.
module rx_cmd_parser
  import rx_cmd_parser_pkg::*;
#(
  parameter int D_WIDTH    = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int FUN_WIDTH  = 4,
  parameter int TIMEOUT    = 1024
) (
  input logic            CLK,
  input logic            RST,
  rx_cmd_parser_if.master bus
);

  state_e                state_q, state_d;
  cmd_type_e             type_q, type_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [D_WIDTH-1:0]    d0_q, d0_d;
  logic [D_WIDTH-1:0]    d1_q, d1_d;
  logic [FUN_WIDTH-1:0]  fun_q, fun_d;
  logic                  valid_q, valid_d;
  logic                  errp_q, errp_d;
  err_code_e             errc_q, errc_d;

  logic     collecting;
  logic     expired;
  logic     timeout;
  opc_dec_t dec;

  assign dec = opc_decode(bus.rx_data[7:0]);

  assign collecting = (state_q == ST_GET_ADDR) ||
                      (state_q == ST_GET_D0)   ||
                      (state_q == ST_GET_D1)   ||
                      (state_q == ST_GET_FUN);

  // a byte in the expiry cycle wins over the timeout
  assign timeout = collecting && expired && !bus.rx_valid;

  frame_timeout_cnt #(
    .TIMEOUT(TIMEOUT)
  ) u_tmo (
    .CLK    (CLK),
    .RST    (RST),
    .clr    (bus.rx_valid || !collecting || expired),
    .inc    (collecting),
    .expired(expired)
  );

  // next-state, field capture and error strobe
  always_comb begin
    state_d = state_q;
    type_d  = type_q;
    addr_d  = addr_q;
    d0_d    = d0_q;
    d1_d    = d1_q;
    fun_d   = fun_q;
    errp_d  = 1'b0;
    errc_d  = errc_q;
    unique case (state_q)
      ST_IDLE, ST_HOLD: begin
        if (state_q == ST_HOLD && !bus.cmd_ready) begin
          if (bus.rx_valid) begin
            errp_d = 1'b1;
            errc_d = ERR_OVERRUN;
          end
        end else if (bus.rx_valid) begin
          state_d = dec.nxt;
          if (dec.ok) begin
            type_d = dec.typ;
          end else begin
            errp_d = 1'b1;
            errc_d = ERR_OPC;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GET_ADDR: begin
        if (bus.rx_valid) begin
          addr_d  = bus.rx_data[ADDR_WIDTH-1:0];
          state_d = (type_q == CMD_WR) ? ST_GET_D0 : ST_HOLD;
        end
      end
      ST_GET_D0: begin
        if (bus.rx_valid) begin
          d0_d    = bus.rx_data;
          state_d = (type_q == CMD_WR) ? ST_HOLD : ST_GET_D1;
        end
      end
      ST_GET_D1: begin
        if (bus.rx_valid) begin
          d1_d    = bus.rx_data;
          state_d = ST_GET_FUN;
        end
      end
      ST_GET_FUN: begin
        if (bus.rx_valid) begin
          fun_d   = bus.rx_data[FUN_WIDTH-1:0];
          state_d = ST_HOLD;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (timeout) begin
      state_d = ST_IDLE;
      errp_d  = 1'b1;
      errc_d  = ERR_TIMEOUT;
    end
    valid_d = (state_d == ST_HOLD);
  end

  // state, datapath and output registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      type_q  <= CMD_WR;
      addr_q  <= '0;
      d0_q    <= '0;
      d1_q    <= '0;
      fun_q   <= '0;
      valid_q <= 1'b0;
      errp_q  <= 1'b0;
      errc_q  <= ERR_NONE;
    end else begin
      state_q <= state_d;
      type_q  <= type_d;
      addr_q  <= addr_d;
      d0_q    <= d0_d;
      d1_q    <= d1_d;
      fun_q   <= fun_d;
      valid_q <= valid_d;
      errp_q  <= errp_d;
      errc_q  <= errc_d;
    end
  end

  assign bus.cmd_valid = valid_q;
  assign bus.cmd_type  = type_q;
  assign bus.cmd_addr  = addr_q;
  assign bus.cmd_d0    = d0_q;
  assign bus.cmd_d1    = d1_q;
  assign bus.cmd_fun   = fun_q;
  assign bus.err_pulse = errp_q;
  assign bus.err_code  = errc_q;

endmodule
